// File: rtl/fixed_mul_scheduler.sv
// Round-robin scheduler sharing one pipelined fixed-point multiplier between
// N_REQ requesters. Each accepted (a, b) pair yields a saturated
// (a*b) >>> FRACTIONAL_SIZE result, strobed back to its requester exactly
// PIPE_STAGES edges after the handshake.
module fixed_mul_scheduler #(
  parameter int N_REQ           = 4,
  parameter int FRACTIONAL_SIZE = 12,
  parameter int OPERAND_SIZE    = 32,
  parameter int PIPE_STAGES     = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ*OPERAND_SIZE-1:0]   req_a,
  input  logic [N_REQ*OPERAND_SIZE-1:0]   req_b,
  output logic [N_REQ-1:0]                resp_valid,
  output logic [OPERAND_SIZE-1:0]         resp_c,
  output logic                            resp_sat,
  output logic                            busy
);

  localparam int W   = OPERAND_SIZE;
  localparam int PW  = 2 * OPERAND_SIZE;
  localparam int IDW = $clog2(N_REQ);

  // Full-width signed product of two sign-extended operands.
  function automatic logic signed [PW-1:0] mul_full(input logic [W-1:0] a,
                                                     input logic [W-1:0] b);
    mul_full = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
  endfunction

  // Floor-shift the product and clip to W bits; returns {clipped, value}.
  function automatic logic [W:0] sat_shift(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p >>> FRACTIONAL_SIZE;
    if (s[PW-1:W-1] == {(W+1){s[PW-1]}})
      sat_shift = {1'b0, s[W-1:0]};
    else if (s[PW-1])
      sat_shift = {1'b1, 1'b1, {(W-1){1'b0}}};
    else
      sat_shift = {1'b1, 1'b0, {(W-1){1'b1}}};
  endfunction

  logic [IDW-1:0]   ptr_reg;
  logic [IDW-1:0]   ptr_next;
  logic [IDW-1:0]   gidx;
  logic [N_REQ-1:0] grant;
  logic [W-1:0]     mux_a;
  logic [W-1:0]     mux_b;

  // Round-robin scan from the pointer; the first valid requester wins.
  // Only req_valid and the pointer are looked at, never the operands.
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_reg) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = IDW'(idx);
      end
    end
  end

  assign req_ready = grant;
  assign mux_a     = req_a[gidx*W +: W];
  assign mux_b     = req_b[gidx*W +: W];

  // Pointer moves just past the winner on a transfer, otherwise holds.
  always_comb begin
    ptr_next = ptr_reg;
    if (|grant)
      ptr_next = (gidx == IDW'(N_REQ-1)) ? '0 : gidx + 1'b1;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

  // One-hot requester id travels alongside the data; zero means empty slot.
  // The last stage is the registered response strobe.
  logic [N_REQ-1:0] id_reg [PIPE_STAGES];

  for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_id
    if (gi == 0) begin : g_first
      // Stage 1 captures the id of the request transferred this edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) id_reg[gi] <= '0;
        else     id_reg[gi] <= grant;
      end
    end else begin : g_next
      // Later stages shift the id along with no stalls.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) id_reg[gi] <= '0;
        else     id_reg[gi] <= id_reg[gi-1];
      end
    end
  end

  // Product feeding the output saturation stage and its matching id.
  logic signed [PW-1:0] final_prod;
  logic [N_REQ-1:0]     final_in;

  if (PIPE_STAGES == 1) begin : g_comb
    assign final_prod = mul_full(mux_a, mux_b);
    assign final_in   = grant;
  end else begin : g_piped
    logic [W-1:0]         a_reg;
    logic [W-1:0]         b_reg;
    logic signed [PW-1:0] p0;

    // Operand register: isolates the arbitration mux from the multiplier.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        a_reg <= '0;
        b_reg <= '0;
      end else if (|grant) begin
        a_reg <= mux_a;
        b_reg <= mux_b;
      end
    end

    assign p0       = mul_full(a_reg, b_reg);
    assign final_in = id_reg[PIPE_STAGES-2];

    if (PIPE_STAGES == 2) begin : g_short
      assign final_prod = p0;
    end else begin : g_chain
      logic signed [PW-1:0] p_reg [PIPE_STAGES-2];
      for (genvar gi = 0; gi < PIPE_STAGES-2; gi++) begin : g_p
        if (gi == 0) begin : g_p0
          // First product register right after the multiplier.
          always_ff @(posedge clk or posedge rst) begin
            if (rst) p_reg[gi] <= '0;
            else     p_reg[gi] <= p0;
          end
        end else begin : g_pn
          // Extra retiming registers for deeper pipelines.
          always_ff @(posedge clk or posedge rst) begin
            if (rst) p_reg[gi] <= '0;
            else     p_reg[gi] <= p_reg[gi-1];
          end
        end
      end
      assign final_prod = p_reg[PIPE_STAGES-3];
    end
  end

  logic [W-1:0] resp_c_reg;
  logic         resp_sat_reg;

  // Result bus updates only when a result lands; otherwise it holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_c_reg   <= '0;
      resp_sat_reg <= 1'b0;
    end else if (|final_in) begin
      {resp_sat_reg, resp_c_reg} <= sat_shift(final_prod);
    end
  end

  assign resp_valid = id_reg[PIPE_STAGES-1];
  assign resp_c     = resp_c_reg;
  assign resp_sat   = resp_sat_reg;

  // Busy whenever any stage holds a live operation.
  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < PIPE_STAGES; s++)
      busy = busy | (|id_reg[s]);
  end

endmodule

// File: tb/tb_fixed_mul_scheduler.sv
// Scoreboard bench for fixed_mul_scheduler: directed vectors with
// hand-computed results; a monitor matches every response strobe against
// the queue of expected results captured at each handshake.
module tb_fixed_mul_scheduler;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   resp_valid;
  logic [W-1:0]   resp_c;
  logic           resp_sat;
  logic           busy;

  fixed_mul_scheduler #(
    .N_REQ(N), .FRACTIONAL_SIZE(12), .OPERAND_SIZE(W), .PIPE_STAGES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_c(resp_c), .resp_sat(resp_sat),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_c   [N];
  logic         exp_sat [N];

  typedef struct {
    int           id;
    logic [W-1:0] c;
    logic         sat;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: record handshakes, check every response against the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (|req_valid)
        chk("grant_legal",
            {63'd0, ($countones(req_ready) <= 1) && ((req_ready & ~req_valid) == '0)},
            64'd1);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          e.id = i; e.c = exp_c[i]; e.sat = exp_sat[i]; e.cyc = cyc;
          sb.push_back(e);
        end
      end
      if (|resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", {60'd0, resp_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          $display("resp id=%0d c=%h sat=%0d (expected c=%h sat=%0d)",
                   e.id, resp_c, resp_sat, e.c, e.sat);
          chk("resp_id", {60'd0, resp_valid}, 64'd1 << e.id);
          chk("resp_c", {32'd0, resp_c}, {32'd0, e.c});
          chk("resp_sat", {63'd0, resp_sat}, {63'd0, e.sat});
          chk("latency", 64'(cyc), 64'(e.cyc + 2));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic s);
    req_valid[i]       = 1'b1;
    req_a[i*W +: W]    = a;
    req_b[i*W +: W]    = b;
    exp_c[i]           = c;
    exp_sat[i]         = s;
  endtask

  task automatic issue1(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic s);
    set_req(i, a, b, c, s);
    @(negedge clk);
    chk($sformatf("ready_r%0d", i), {60'd0, req_ready}, 64'd1 << i);
    tick();
    req_valid[i] = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin exp_c[i] = '0; exp_sat[i] = 1'b0; end
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_ready", {60'd0, req_ready}, 64'd0);
    chk("rst_resp_valid", {60'd0, resp_valid}, 64'd0);
    chk("rst_resp_c", {32'd0, resp_c}, 64'd0);
    chk("rst_resp_sat", {63'd0, resp_sat}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Arithmetic: basic, sign, floor, both saturation directions.
    issue1(0, 32'h0000_2000, 32'h0000_3000, 32'h0000_6000, 1'b0);
    issue1(1, 32'hFFFF_E800, 32'h0000_2000, 32'hFFFF_D000, 1'b0);
    issue1(2, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    issue1(3, 32'h4000_0000, 32'h4000_0000, 32'h7FFF_FFFF, 1'b1);
    issue1(0, 32'h4000_0000, 32'hC000_0000, 32'h8000_0000, 1'b1);

    // Fairness: all requesters valid straight out of reset.
    rst = 1'b1;
    for (int i = 0; i < N; i++)
      set_req(i, W'((i + 1) << 12), 32'h0000_1000, W'((i + 1) << 12), 1'b0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("fair_grant_%0d", k), {60'd0, req_ready}, 64'd1 << (k % 4));
      if (k > 0) chk($sformatf("fair_busy_%0d", k), {63'd0, busy}, 64'd1);
      tick();
    end
    req_valid = '0;
    repeat (4) tick();

    // Skip and wrap: move pointer to 3, then only requesters 1 and 3 valid.
    issue1(2, 32'h0000_2000, 32'h0000_2000, 32'h0000_4000, 1'b0);
    set_req(1, 32'h0000_5000, 32'h0000_0800, 32'h0000_2800, 1'b0);
    set_req(3, 32'h0000_3000, 32'hFFFF_F000, 32'hFFFF_D000, 1'b0);
    begin
      int seq [3] = '{3, 1, 3};
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk($sformatf("skip_grant_%0d", k), {60'd0, req_ready}, 64'd1 << seq[k]);
        tick();
      end
    end
    req_valid = '0;
    repeat (4) tick();

    // Reset mid-flight: two ops issued, reset before they can be observed.
    set_req(0, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 1'b0);
    set_req(1, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000, 1'b0);
    @(negedge clk);
    chk("mid_grant_0", {60'd0, req_ready}, 64'd1);
    tick();
    @(negedge clk);
    chk("mid_grant_1", {60'd0, req_ready}, 64'd2);
    tick();
    req_valid = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst_resp_%0d", k), {60'd0, resp_valid}, 64'd0);
      chk($sformatf("post_rst_busy_%0d", k), {63'd0, busy}, 64'd0);
      tick();
    end
    for (int i = 0; i < N; i++)
      set_req(i, W'((i + 1) << 12), 32'h0000_1000, W'((i + 1) << 12), 1'b0);
    @(negedge clk);
    chk("post_rst_ptr", {60'd0, req_ready}, 64'd1);
    tick();
    req_valid = '0;
    repeat (4) tick();

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
